register_file: RTL and testbench
================================

# register_file

Architectural register file directly downstream of the 5-stage pipeline's write-back stage and feeding its decode stage. Provides two asynchronous read ports and one synchronous write port, with register 0 hard-wired to zero. An optional same-cycle write-to-read bypass is available. A valid/ready debug dump port streams the full register contents out on request.

## Interface
- NUM_REGS, 32, number of architectural registers (power of two, ≤ 2^ADDR_WIDTH)
- ADDR_WIDTH, 6, width of read and write address ports
- DATA_WIDTH, 32, register width

- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- read_address_1  in  ADDR_WIDTH  read port 1 address
- read_value_1  out  DATA_WIDTH  read port 1 data (combinational)
- read_address_2  in  ADDR_WIDTH  read port 2 address
- read_value_2  out  DATA_WIDTH  read port 2 data (combinational)
- write_address  in  ADDR_WIDTH  write address
- write_value  in  DATA_WIDTH  write data
- write_enable  in  1  write strobe, sampled on the rising edge
- dump_start  in  1  request a full register dump (sampled in IDLE only)
- dump_ready  in  1  consumer accepts the current beat
- dump_valid  out  1  dump beat present
- dump_index  out  log2(NUM_REGS)  register number of the current beat
- dump_value  out  DATA_WIDTH  register contents of the current beat
- dump_busy  out  1  dump in progress (DUMP or DONE state)
- dump_done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Reset clears all registers to 0. Outputs after reset: dump_valid, dump_busy, dump_done = 0; dump_index = 0; dump_value = 0.
- Write:
  - On the rising edge with write_enable=1, write_address in 1..NUM_REGS-1 loads write_value.
  - Writes to address 0 or to addresses ≥ NUM_REGS are ignored.
- Read: read_value_n = regs[read_address_n]. Address 0 and addresses ≥ NUM_REGS read 0.
- Both read ports may address the same register; each returns the same value.
- Dump FSM states and transitions:
  - IDLE: if dump_start=1, go to DUMP with dump_index=0 and dump_value=regs[0].
  - DUMP: dump_valid=1. On dump_valid && dump_ready:
    - if dump_index == NUM_REGS-1, go to DONE;
    - otherwise increment dump_index and capture regs[index+1] into dump_value.
  - DONE: dump_done=1 for one cycle, then return to IDLE. A dump_start sampled in this cycle is ignored.
- The dump does not block normal reads or writes.
- dump_value is registered and captures the register contents as they stood before the capturing edge. A write on that same edge is not reflected.
- dump_index and dump_value stay stable while dump_valid && !dump_ready, even if the dumped register is written.
- dump_start is ignored while dump_busy=1.
- Reset asserted mid-dump returns the FSM to IDLE and clears every register on the same edge.

## Timing
- Write latency: a write committed on edge N is visible on the read ports from the cycle following edge N.
- Read latency: zero (combinational from address).
- Dump, with dump_start sampled at edge 0 and dump_ready held at 1:
  - dump_valid high from edge 1 through edge 32, one beat per cycle;
  - dump_done pulses for the cycle after edge 32;
  - dump_busy high from edge 1 until edge 33.
- Dump with back-pressure: each cycle of dump_ready=0 extends the dump by exactly one cycle.

## Configuration
- REGISTER_FILE_BYPASS_EN, when defined:
  - If write_enable=1, write_address == read_address_n, and that address is nonzero and < NUM_REGS, read_value_n returns write_value in the same cycle.
  - This covers the write-back/decode overlap that the pipeline's own forwarding does not.
- When undefined: reads return stored contents only, and the new value appears the following cycle.
- The dump port never bypasses, in either configuration.

## Structure
- Shared package register_file_pkg holds:
  - default constants NUM_REGS, ADDR_WIDTH, DATA_WIDTH;
  - the dump state enum (IDLE, DUMP, DONE).
- One sub-module, register_file_dump, holds the dump FSM, index counter and dump_value capture. It reads the storage array through an index/data pair.

## Test plan
- Reset, then read addresses 0, 5 and 63 -> all return 0. dump_valid=0, dump_busy=0.
- Write 0xDEADBEEF to r5 at edge N, read r5 on port 1 and port 2 in cycle N+1 -> both return 0xDEADBEEF. Write 0x1234 to r0 -> r0 still reads 0. Write 0x1234 to address 40 -> no register changes.
- Same-cycle write of 0xA5A5A5A5 to r7 while reading r7:
  - with REGISTER_FILE_BYPASS_EN -> read returns 0xA5A5A5A5 that cycle;
  - without it -> read returns the old value, then 0xA5A5A5A5 next cycle.
- Load r1..r31 with value = 0x100 + index, dump with dump_ready=1 -> 32 consecutive beats with index 0..31 and values 0, 0x101..0x11F. dump_done pulses once, on the cycle after the last beat.
- Dump with dump_ready toggling every other cycle, plus a write of 0xFFFF to r3 while beat 3 is stalled -> index 3 value remains 0x103 until accepted. Total duration is 32 accepted beats plus the stall count. A dump_start pulse during the dump is ignored.
- Assert reset during beat 10 -> next cycle dump_valid=0, dump_busy=0, and all registers read 0. A fresh dump_start then dumps all zeros.

Source files
------------

// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_pkg
// Description : Shared default sizes and the dump state encoding for the
//               architectural register file.
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_pkg;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_WIDTH = 6;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } dump_state_t;

endpackage
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_if
// Description : Read/write/dump signal bundle between the pipeline (master)
//               and the register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_if #(
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int IDX_WIDTH  = $clog2(register_file_pkg::NUM_REGS)
);
    logic [ADDR_WIDTH-1:0] read_address_1;
    logic [DATA_WIDTH-1:0] read_value_1;
    logic [ADDR_WIDTH-1:0] read_address_2;
    logic [DATA_WIDTH-1:0] read_value_2;
    logic [ADDR_WIDTH-1:0] write_address;
    logic [DATA_WIDTH-1:0] write_value;
    logic                  write_enable;
    logic                  dump_start;
    logic                  dump_ready;
    logic                  dump_valid;
    logic [IDX_WIDTH-1:0]  dump_index;
    logic [DATA_WIDTH-1:0] dump_value;
    logic                  dump_busy;
    logic                  dump_done;

    modport slave (
        input  read_address_1, read_address_2, write_address, write_value,
               write_enable, dump_start, dump_ready,
        output read_value_1, read_value_2, dump_valid, dump_index,
               dump_value, dump_busy, dump_done
    );

    modport master (
        output read_address_1, read_address_2, write_address, write_value,
               write_enable, dump_start, dump_ready,
        input  read_value_1, read_value_2, dump_valid, dump_index,
               dump_value, dump_busy, dump_done
    );
endinterface
`default_nettype wire

// File: rtl/register_file_dump.sv
`default_nettype none
// ============================================================================
// Module      : register_file_dump
// Description : Valid/ready dump engine that walks every register once,
//               holding index and captured value stable under back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_dump #(
    parameter int NUM_REGS   = register_file_pkg::NUM_REGS,
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int IDX_WIDTH  = $clog2(NUM_REGS)
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  dump_start_i,
    input  wire logic                  dump_ready_i,
    output logic [IDX_WIDTH-1:0]       rd_index_o,
    input  wire logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                       dump_valid_o,
    output logic [IDX_WIDTH-1:0]       dump_index_o,
    output logic [DATA_WIDTH-1:0]      dump_value_o,
    output logic                       dump_busy_o,
    output logic                       dump_done_o
);
    import register_file_pkg::*;

    localparam logic [IDX_WIDTH-1:0] c_last_index = IDX_WIDTH'(NUM_REGS - 1);

    dump_state_t           state_q, state_d;
    logic [IDX_WIDTH-1:0]  index_q, index_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_capture;

    assign w_accept = (state_q == DUMP) && dump_ready_i;
    assign w_last   = (index_q == c_last_index);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (dump_start_i) state_d = DUMP;
            DUMP:    if (w_accept && w_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The storage is looked up at the next index so the capture edge sees
    // the contents as they stood before that edge.
    always_comb begin
        w_capture = 1'b0;
        index_d   = index_q;
        unique case (state_q)
            IDLE: if (dump_start_i) begin
                w_capture = 1'b1;
                index_d   = '0;
            end
            DUMP: if (w_accept && !w_last) begin
                w_capture = 1'b1;
                index_d   = index_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_index_o = index_d;
    assign value_d    = w_capture ? rd_data_i : value_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            index_q <= '0;
            value_q <= '0;
        end else begin
            index_q <= index_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        dump_valid_o = (state_q == DUMP);
        dump_busy_o  = (state_q != IDLE);
        dump_done_o  = (state_q == DONE);
        dump_index_o = index_q;
        dump_value_o = value_q;
    end

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : Two-read/one-write architectural register file, r0 tied to
//               zero, with a streaming dump port. Defining
//               REGISTER_FILE_BYPASS_EN forwards a same-cycle write to reads.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int NUM_REGS   = register_file_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH
) (
    input wire logic         clock,
    input wire logic         reset,
    register_file_if.slave   bus
);
    import register_file_pkg::*;

    localparam int IDX_WIDTH = $clog2(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic                  w_wr_ok;
    logic [IDX_WIDTH-1:0]  w_dump_rd_index;
    logic [DATA_WIDTH-1:0] w_dump_rd_data;

    // Usable addresses are nonzero and below NUM_REGS (a power of two).
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && ((a >> IDX_WIDTH) == '0);
    endfunction

    assign w_wr_ok = bus.write_enable && addr_ok(bus.write_address);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_ok) begin
            regs_q[bus.write_address[IDX_WIDTH-1:0]] <= bus.write_value;
        end
    end

    always_comb begin
        bus.read_value_1 = addr_ok(bus.read_address_1)
                         ? regs_q[bus.read_address_1[IDX_WIDTH-1:0]] : '0;
        bus.read_value_2 = addr_ok(bus.read_address_2)
                         ? regs_q[bus.read_address_2[IDX_WIDTH-1:0]] : '0;
`ifdef REGISTER_FILE_BYPASS_EN
        if (w_wr_ok && (bus.write_address == bus.read_address_1)) begin
            bus.read_value_1 = bus.write_value;
        end
        if (w_wr_ok && (bus.write_address == bus.read_address_2)) begin
            bus.read_value_2 = bus.write_value;
        end
`endif
    end

    // The dump path reads stored contents only, never the bypass.
    assign w_dump_rd_data = regs_q[w_dump_rd_index];

    register_file_dump #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_dump (
        .clock        (clock),
        .reset        (reset),
        .dump_start_i (bus.dump_start),
        .dump_ready_i (bus.dump_ready),
        .rd_index_o   (w_dump_rd_index),
        .rd_data_i    (w_dump_rd_data),
        .dump_valid_o (bus.dump_valid),
        .dump_index_o (bus.dump_index),
        .dump_value_o (bus.dump_value),
        .dump_busy_o  (bus.dump_busy),
        .dump_done_o  (bus.dump_done)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench for register_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    register_file_if bus ();

    register_file dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.read_address_1 = '0;
        bus.read_address_2 = '0;
        bus.write_address  = '0;
        bus.write_value    = '0;
        bus.write_enable   = 1'b0;
        bus.dump_start     = 1'b0;
        bus.dump_ready     = 1'b0;
    endtask

    task automatic test_reset();
        int addrs [3] = '{0, 5, 63};
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        foreach (addrs[k]) begin
            bus.read_address_1 = 6'(addrs[k]);
            bus.read_address_2 = 6'(addrs[k]);
            #1;
            checks++;
            if (bus.read_value_1 !== 32'h0) begin
                failures++;
                $display("FAIL reset_read1 addr=%0d got=%h exp=0", addrs[k], bus.read_value_1);
            end
            checks++;
            if (bus.read_value_2 !== 32'h0) begin
                failures++;
                $display("FAIL reset_read2 addr=%0d got=%h exp=0", addrs[k], bus.read_value_2);
            end
        end
        checks++;
        if ({bus.dump_valid, bus.dump_busy, bus.dump_done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_dump_flags got=%b exp=000",
                     {bus.dump_valid, bus.dump_busy, bus.dump_done});
        end
        checks++;
        if (bus.dump_index !== 5'd0 || bus.dump_value !== 32'h0) begin
            failures++;
            $display("FAIL reset_dump_data idx=%0d val=%h exp 0/0", bus.dump_index, bus.dump_value);
        end
    endtask

    task automatic test_write();
        logic [31:0] exp;
        bus.write_enable  = 1'b1;
        bus.write_address = 6'd5;
        bus.write_value   = 32'hDEADBEEF;
        step();
        bus.write_enable   = 1'b0;
        bus.read_address_1 = 6'd5;
        bus.read_address_2 = 6'd5;
        #1;
        checks++;
        if (bus.read_value_1 !== 32'hDEADBEEF || bus.read_value_2 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_r5 got=%h/%h exp=deadbeef", bus.read_value_1, bus.read_value_2);
        end
        bus.write_enable  = 1'b1;
        bus.write_address = 6'd0;
        bus.write_value   = 32'h1234;
        step();
        bus.write_enable   = 1'b0;
        bus.read_address_1 = 6'd0;
        #1;
        checks++;
        if (bus.read_value_1 !== 32'h0) begin
            failures++;
            $display("FAIL write_r0 got=%h exp=0", bus.read_value_1);
        end
        bus.write_enable  = 1'b1;
        bus.write_address = 6'd40;
        step();
        bus.write_enable = 1'b0;
        for (int a = 0; a < 64; a++) begin
            bus.read_address_1 = 6'(a);
            #1;
            exp = (a == 5) ? 32'hDEADBEEF : 32'h0;
            checks++;
            if (bus.read_value_1 !== exp) begin
                failures++;
                $display("FAIL write_out_of_range addr=%0d got=%h exp=%h", a, bus.read_value_1, exp);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
        bus.write_enable  = 1'b1;
        bus.write_address = 6'd7;
        bus.write_value   = 32'h77;
        step();
        bus.write_value    = 32'hA5A5A5A5;
        bus.read_address_1 = 6'd7;
        bus.read_address_2 = 6'd8;
        #1;
`ifdef REGISTER_FILE_BYPASS_EN
        exp = 32'hA5A5A5A5;
`else
        exp = 32'h77;
`endif
        checks++;
        if (bus.read_value_1 !== exp) begin
            failures++;
            $display("FAIL bypass_same_cycle got=%h exp=%h", bus.read_value_1, exp);
        end
        checks++;
        if (bus.read_value_2 !== 32'h0) begin
            failures++;
            $display("FAIL bypass_other_port got=%h exp=0", bus.read_value_2);
        end
        step();
        bus.write_enable = 1'b0;
        #1;
        checks++;
        if (bus.read_value_1 !== 32'hA5A5A5A5) begin
            failures++;
            $display("FAIL bypass_next_cycle got=%h exp=a5a5a5a5", bus.read_value_1);
        end
        bus.write_enable   = 1'b1;
        bus.write_address  = 6'd0;
        bus.write_value    = 32'hFFFFFFFF;
        bus.read_address_1 = 6'd0;
        #1;
        checks++;
        if (bus.read_value_1 !== 32'h0) begin
            failures++;
            $display("FAIL bypass_r0 got=%h exp=0", bus.read_value_1);
        end
        step();
        bus.write_enable = 1'b0;
    endtask

    task automatic test_dump_full();
        int beat = 0, dones = 0, cycles = 0;
        logic [31:0] exp;
        for (int i = 1; i < 32; i++) begin
            bus.write_enable  = 1'b1;
            bus.write_address = 6'(i);
            bus.write_value   = 32'h100 + 32'(i);
            step();
        end
        bus.write_enable = 1'b0;
        bus.dump_ready   = 1'b1;
        bus.dump_start   = 1'b1;
        step();
        bus.dump_start = 1'b0;
        while (cycles < 200) begin
            #1;
            if (bus.dump_done) begin
                dones++;
                checks++;
                if (beat != 32) begin
                    failures++;
                    $display("FAIL full_done_timing beats=%0d exp=32", beat);
                end
            end
            if (bus.dump_valid) begin
                exp = (beat == 0) ? 32'h0 : 32'h100 + 32'(beat);
                checks++;
                if (bus.dump_index !== 5'(beat) || bus.dump_value !== exp) begin
                    failures++;
                    $display("FAIL full_beat beat=%0d idx=%0d val=%h exp_val=%h",
                             beat, bus.dump_index, bus.dump_value, exp);
                end
                beat++;
            end
            if (!bus.dump_busy) break;
            step();
            cycles++;
        end
        checks++;
        if (cycles != 33 || dones != 1 || beat != 32) begin
            failures++;
            $display("FAIL full_duration cycles=%0d dones=%0d beats=%0d exp 33/1/32", cycles, dones, beat);
        end
    endtask

    task automatic test_backpressure();
        int beat = 0, stalls = 0, cycles = 0;
        logic written = 1'b0;
        logic [31:0] exp;
        bus.dump_ready = 1'b0;
        bus.dump_start = 1'b1;
        step();
        while (cycles < 300) begin
            bus.dump_ready   = (cycles % 2) == 1;
            bus.dump_start   = (cycles == 10) || bus.dump_done;
            bus.write_enable = 1'b0;
            if (bus.dump_valid && bus.dump_index == 5'd3 && !bus.dump_ready && !written) begin
                bus.write_enable  = 1'b1;
                bus.write_address = 6'd3;
                bus.write_value   = 32'hFFFF;
                written           = 1'b1;
            end
            #1;
            if (bus.dump_valid) begin
                exp = (beat == 0) ? 32'h0 : 32'h100 + 32'(beat);
                checks++;
                if (bus.dump_index !== 5'(beat) || bus.dump_value !== exp) begin
                    failures++;
                    $display("FAIL bp_beat beat=%0d idx=%0d val=%h exp_val=%h",
                             beat, bus.dump_index, bus.dump_value, exp);
                end
                if (bus.dump_ready) beat++;
                else stalls++;
            end
            if (!bus.dump_busy) break;
            step();
            cycles++;
        end
        bus.dump_start     = 1'b0;
        bus.write_enable   = 1'b0;
        bus.read_address_1 = 6'd3;
        #1;
        checks++;
        if (cycles != 65 || stalls != 32 || beat != 32) begin
            failures++;
            $display("FAIL bp_duration cycles=%0d stalls=%0d beats=%0d exp 65/32/32", cycles, stalls, beat);
        end
        checks++;
        if (bus.read_value_1 !== 32'hFFFF) begin
            failures++;
            $display("FAIL bp_r3_written got=%h exp=ffff", bus.read_value_1);
        end
    endtask

    task automatic test_reset_mid_dump();
        int n = 0, beat = 0, cycles = 0;
        bus.dump_ready = 1'b1;
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        while (!(bus.dump_valid && bus.dump_index == 5'd10) && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n != 10) begin
            failures++;
            $display("FAIL mid_reach_beat10 cycles=%0d exp=10", n);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.dump_valid, bus.dump_busy, bus.dump_done} !== 3'b000 ||
            bus.dump_index !== 5'd0 || bus.dump_value !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_dump flags=%b idx=%0d val=%h exp 000/0/0",
                     {bus.dump_valid, bus.dump_busy, bus.dump_done}, bus.dump_index, bus.dump_value);
        end
        for (int a = 0; a < 32; a++) begin
            bus.read_address_1 = 6'(a);
            bus.read_address_2 = 6'(31 - a);
            #1;
            checks++;
            if (bus.read_value_1 !== 32'h0 || bus.read_value_2 !== 32'h0) begin
                failures++;
                $display("FAIL mid_reset_regs addr=%0d got=%h/%h exp=0", a, bus.read_value_1, bus.read_value_2);
            end
        end
        bus.dump_start = 1'b1;
        step();
        bus.dump_start = 1'b0;
        while (cycles < 200) begin
            #1;
            if (bus.dump_valid) begin
                checks++;
                if (bus.dump_index !== 5'(beat) || bus.dump_value !== 32'h0) begin
                    failures++;
                    $display("FAIL zero_beat beat=%0d idx=%0d val=%h exp_val=0",
                             beat, bus.dump_index, bus.dump_value);
                end
                beat++;
            end
            if (!bus.dump_busy) break;
            step();
            cycles++;
        end
        checks++;
        if (cycles != 33 || beat != 32) begin
            failures++;
            $display("FAIL zero_duration cycles=%0d beats=%0d exp 33/32", cycles, beat);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_write();
        test_bypass();
        test_dump_full();
        test_backpressure();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
